// File: rtl/boton_acondicionador_pulsos.sv
// Pushbutton front end for the setpoint counter: synchronize, debounce, resolve
// conflicting presses and emit single-cycle up/down pulses with auto-repeat.
module boton_acondicionador_pulsos #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000,
  parameter int unsigned CNT_W           = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up_raw,
  input  logic btn_down_raw,
  input  logic enable,
  output logic pulse_up,
  output logic pulse_down,
  output logic up_stable,
  output logic down_stable
);

  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX   = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    HOLD_UP,
    HOLD_DOWN,
    REPEAT_UP,
    REPEAT_DOWN,
    LOCKOUT
  } state_t;

  // Bit 0 is the increase button, bit 1 the decrease button.
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] stable;
  logic [1:0] stable_prev;
  logic [1:0] toggle;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_d;
  logic             pulse_up_d;
  logic             pulse_down_d;
  logic             up_rise;
  logic             down_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1       <= '0;
      sync2       <= '0;
      stable      <= '0;
      stable_prev <= '0;
    end else begin
      sync1       <= {btn_down_raw, btn_up_raw};
      sync2       <= sync1;
      stable      <= stable ^ toggle;
      stable_prev <= stable;
    end
  end

  // Per-button debounce: count consecutive samples that disagree with the stable level.
  for (genvar i = 0; i < 2; i++) begin : g_db
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt <= '0;
      end else if ((sync2[i] == stable[i]) || (cnt == DB_LAST)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign toggle[i] = (sync2[i] != stable[i]) && (cnt == DB_LAST);
  end

  assign up_stable   = stable[0];
  assign down_stable = stable[1];
  assign up_rise     = stable[0] & ~stable_prev[0];
  assign down_rise   = stable[1] & ~stable_prev[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      pulse_up   <= 1'b0;
      pulse_down <= 1'b0;
    end else begin
      state      <= state_next;
      timer      <= timer_d;
      pulse_up   <= pulse_up_d;
      pulse_down <= pulse_down_d;
    end
  end

  // Next state; a second button always wins over an active hold by locking out.
  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = (|stable) ? LOCKOUT : IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (up_rise && !stable[1])        state_next = HOLD_UP;
          else if (down_rise && !stable[0]) state_next = HOLD_DOWN;
          else if (up_rise || down_rise)    state_next = LOCKOUT;
        end
        HOLD_UP, REPEAT_UP: begin
          if (stable[1])       state_next = LOCKOUT;
          else if (!stable[0]) state_next = IDLE;
          else if ((state == HOLD_UP) && (timer == DELAY_LAST)) state_next = REPEAT_UP;
        end
        HOLD_DOWN, REPEAT_DOWN: begin
          if (stable[0])       state_next = LOCKOUT;
          else if (!stable[1]) state_next = IDLE;
          else if ((state == HOLD_DOWN) && (timer == DELAY_LAST)) state_next = REPEAT_DOWN;
        end
        LOCKOUT: begin
          if (stable == 2'b00) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Pulse and timer outputs; the timer restarts on every pulse and saturates otherwise.
  always_comb begin
    pulse_up_d   = 1'b0;
    pulse_down_d = 1'b0;
    timer_d      = (timer == TIMER_MAX) ? timer : timer + CNT_W'(1);
    unique case (state)
      IDLE: begin
        pulse_up_d   = (state_next == HOLD_UP);
        pulse_down_d = (state_next == HOLD_DOWN);
      end
      HOLD_UP:     pulse_up_d   = (state_next == REPEAT_UP);
      HOLD_DOWN:   pulse_down_d = (state_next == REPEAT_DOWN);
      REPEAT_UP:   pulse_up_d   = (state_next == REPEAT_UP) && (timer == PERIOD_LAST);
      REPEAT_DOWN: pulse_down_d = (state_next == REPEAT_DOWN) && (timer == PERIOD_LAST);
      default: ;
    endcase
    pulse_up_d   = pulse_up_d & enable;
    pulse_down_d = pulse_down_d & enable;
    if (pulse_up_d || pulse_down_d || (state_next inside {IDLE, LOCKOUT})) begin
      timer_d = '0;
    end
  end

endmodule

// File: tb/tb_boton_acondicionador_pulsos.sv
// Bench for boton_acondicionador_pulsos: expected pulse cycles are queued when a
// press is driven and matched by a monitor as the DUT emits them.
module tb_boton_acondicionador_pulsos;

  localparam int unsigned D  = 4;
  localparam int unsigned RD = 20;
  localparam int unsigned RP = 5;
  localparam int unsigned W  = 26;

  logic clk = 1'b0;
  logic reset;
  logic btn_up_raw;
  logic btn_down_raw;
  logic enable;
  logic pulse_up;
  logic pulse_down;
  logic up_stable;
  logic down_stable;

  boton_acondicionador_pulsos #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .CNT_W          (W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_up_raw  (btn_up_raw),
    .btn_down_raw(btn_down_raw),
    .enable      (enable),
    .pulse_up    (pulse_up),
    .pulse_down  (pulse_down),
    .up_stable   (up_stable),
    .down_stable (down_stable)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; at a falling edge cyc == k means edge k just happened.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit dir;      // 0 = up, 1 = down
    int cyc_at;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   prev_up = 1'b0;
  bit   prev_down = 1'b0;
  exp_t mon_e;

  // Scoreboard monitor: every observed pulse must match the head of the queue.
  always @(negedge clk) begin
    if (pulse_up || pulse_down) begin
      tests++;
      if (pulse_up && pulse_down) begin
        fails++;
        $display("FAIL both_pulses cyc=%0d up=%b down=%b required one at most", cyc, pulse_up, pulse_down);
      end else if ((pulse_up && prev_up) || (pulse_down && prev_down)) begin
        fails++;
        $display("FAIL wide_pulse cyc=%0d up=%b down=%b required single-cycle", cyc, pulse_up, pulse_down);
      end else if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse cyc=%0d up=%b down=%b required none", cyc, pulse_up, pulse_down);
      end else begin
        mon_e = exp_q.pop_front();
        if ((mon_e.dir !== pulse_down) || (mon_e.cyc_at !== cyc)) begin
          fails++;
          $display("FAIL pulse_match got dir=%0d cyc=%0d required dir=%0d cyc=%0d",
                   pulse_down, cyc, mon_e.dir, mon_e.cyc_at);
        end
      end
    end
    prev_up   = pulse_up;
    prev_down = pulse_down;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d required completion", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input bit dir, input int at);
    exp_t e;
    e.dir    = dir;
    e.cyc_at = at;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_up_raw = 1'b0; btn_down_raw = 1'b0; enable = 1'b1;
    step(3);
    tests += 4;
    if (pulse_up !== 1'b0)    begin fails++; $display("FAIL reset_pulse_up got=%b required=0", pulse_up); end
    if (pulse_down !== 1'b0)  begin fails++; $display("FAIL reset_pulse_down got=%b required=0", pulse_down); end
    if (up_stable !== 1'b0)   begin fails++; $display("FAIL reset_up_stable got=%b required=0", up_stable); end
    if (down_stable !== 1'b0) begin fails++; $display("FAIL reset_down_stable got=%b required=0", down_stable); end
    reset = 1'b0;
    step(3);
  endtask

  task automatic test_single_press();
    int c;
    c = cyc;
    btn_up_raw = 1'b1;
    push_exp(1'b0, c + 3 + D);
    step(D + 1);
    tests++;
    if (up_stable !== 1'b0) begin fails++; $display("FAIL press_stable_early got=%b required=0", up_stable); end
    step(1);
    tests++;
    if (up_stable !== 1'b1) begin fails++; $display("FAIL press_stable_on_time got=%b required=1", up_stable); end
    step(3);
    btn_up_raw = 1'b0;
    step(D + 6);
    tests += 2;
    if (up_stable !== 1'b0) begin fails++; $display("FAIL press_release_stable got=%b required=0", up_stable); end
    if (exp_q.size() != 0) begin fails++; $display("FAIL press_missing got=%0d pending required=0", exp_q.size()); end
  endtask

  task automatic test_glitch();
    bit seen;
    for (int r = 0; r < 4; r++) begin
      seen = 1'b0;
      btn_down_raw = 1'b1;
      for (int k = 0; k < 3; k++) begin step(1); seen |= down_stable; end
      btn_down_raw = 1'b0;
      for (int k = 0; k < 6; k++) begin step(1); seen |= down_stable; end
      tests++;
      if (seen) begin fails++; $display("FAIL glitch_stable round=%0d got=1 required=0", r); end
    end
    step(D + 4);
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL glitch_queue got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_repeat();
    int c;
    int p;
    c = cyc;
    p = c + 3 + D;
    btn_up_raw = 1'b1;
    push_exp(1'b0, p);
    // Release is timed so the stable level falls at edge p+59.
    for (int t = p + RD; t < p + 59; t += RP) push_exp(1'b0, t);
    step(p + 57 - D - c);
    btn_up_raw = 1'b0;
    step(D + 12);
    tests += 2;
    if (up_stable !== 1'b0) begin fails++; $display("FAIL repeat_release_stable got=%b required=0", up_stable); end
    if (exp_q.size() != 0) begin fails++; $display("FAIL repeat_missing got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_both();
    int c;
    btn_up_raw = 1'b1; btn_down_raw = 1'b1;
    step(D + 8);
    tests++;
    if ({up_stable, down_stable} !== 2'b11) begin
      fails++; $display("FAIL both_stable got=%b%b required=11", up_stable, down_stable);
    end
    btn_up_raw = 1'b0;
    step(D + 8);
    tests++;
    if ({up_stable, down_stable} !== 2'b01) begin
      fails++; $display("FAIL both_up_released got=%b%b required=01", up_stable, down_stable);
    end
    btn_down_raw = 1'b0;
    step(D + 8);
    c = cyc;
    btn_down_raw = 1'b1;
    push_exp(1'b1, c + 3 + D);
    step(D + 6);
    btn_down_raw = 1'b0;
    step(D + 8);
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL both_missing got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_lockout();
    int c;
    int p;
    c = cyc;
    p = c + 3 + D;
    btn_up_raw = 1'b1;
    push_exp(1'b0, p);
    push_exp(1'b0, p + RD);
    push_exp(1'b0, p + RD + RP);
    // Down becomes stable at edge p+27, between two repeats.
    step(p + 25 - D - c);
    btn_down_raw = 1'b1;
    step(40);
    tests++;
    if ({up_stable, down_stable} !== 2'b11) begin
      fails++; $display("FAIL lockout_stable got=%b%b required=11", up_stable, down_stable);
    end
    btn_up_raw = 1'b0;
    step(D + 8);
    btn_down_raw = 1'b0;
    step(D + 8);
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL lockout_queue got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int c;
    int p;
    c = cyc;
    p = c + 3 + D;
    btn_down_raw = 1'b1;
    push_exp(1'b1, p);
    push_exp(1'b1, p + RD);
    step(p + RD + 2 - c);
    #1 reset = 1'b1;
    #1;
    tests += 4;
    if (pulse_up !== 1'b0)    begin fails++; $display("FAIL midrst_pulse_up got=%b required=0", pulse_up); end
    if (pulse_down !== 1'b0)  begin fails++; $display("FAIL midrst_pulse_down got=%b required=0", pulse_down); end
    if (up_stable !== 1'b0)   begin fails++; $display("FAIL midrst_up_stable got=%b required=0", up_stable); end
    if (down_stable !== 1'b0) begin fails++; $display("FAIL midrst_down_stable got=%b required=0", down_stable); end
    step(3);
    reset = 1'b0;
    c = cyc;
    push_exp(1'b1, c + 3 + D);
    step(D + 1);
    tests++;
    if (down_stable !== 1'b0) begin fails++; $display("FAIL midrst_restable_early got=%b required=0", down_stable); end
    step(1);
    tests++;
    if (down_stable !== 1'b1) begin fails++; $display("FAIL midrst_restable got=%b required=1", down_stable); end
    step(3);
    btn_down_raw = 1'b0;
    step(D + 8);
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL midrst_queue got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_enable();
    int c;
    enable = 1'b0;
    btn_up_raw = 1'b1;
    step(D + 8);
    tests++;
    if (up_stable !== 1'b1) begin fails++; $display("FAIL enable_tracking got=%b required=1", up_stable); end
    enable = 1'b1;
    step(RD + 10);
    btn_up_raw = 1'b0;
    step(D + 8);
    tests++;
    if (up_stable !== 1'b0) begin fails++; $display("FAIL enable_release got=%b required=0", up_stable); end
    c = cyc;
    btn_up_raw = 1'b1;
    push_exp(1'b0, c + 3 + D);
    step(D + 6);
    btn_up_raw = 1'b0;
    step(D + 8);
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL enable_queue got=%0d required=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_repeat();
    test_both();
    test_lockout();
    test_reset_mid();
    test_enable();
    step(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
